// File: rtl/fft_output_serializer.sv
// Ping-pong frame buffer that turns one parallel FFT frame into a bin-by-bin
// valid/ready stream, dropping whole frames when both banks are occupied.
package fft_output_serializer_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_product_t;
endpackage

module fft_output_serializer
  import fft_output_serializer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  complex_product_t [N-1:0] frame_in,
  input  logic                    frame_valid,
  input  logic                    frame_mode,
  output complex_product_t        out_data,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_mode,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  complex_product_t [N-1:0] bank [2];
  logic [1:0]    full;
  logic [1:0]    mode;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] rd_idx;

  logic xfer;
  logic last_xfer;
  logic avail;
  logic capture;

  // Handshake: a bin moves downstream on any rising edge where out_valid and
  // out_ready are both high; out_valid only falls after the last bin of the
  // last buffered frame has transferred (or on reset).
  assign out_valid = full[rd_bank];
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (rd_idx == LAST_IDX);

  // A full bank may be overwritten in the very cycle its final bin leaves.
  assign avail   = !full[wr_bank] || ((wr_bank == rd_bank) && last_xfer);
  assign capture = frame_valid && avail;

  assign out_data  = bank[rd_bank][rd_idx];
  assign out_index = rd_idx;
  assign out_last  = out_valid && (rd_idx == LAST_IDX);
  assign out_mode  = mode[rd_bank];

  always_ff @(posedge clk) begin
    if (reset && capture) begin
      bank[wr_bank] <= frame_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full       <= '0;
      mode       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= frame_valid && !avail;
      if (frame_valid && !avail && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
      if (xfer) begin
        rd_idx <= last_xfer ? '0 : rd_idx + 1'b1;
        if (last_xfer) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
      // Placed after the release above so a same-cycle refill wins.
      if (capture) begin
        full[wr_bank] <= 1'b1;
        mode[wr_bank] <= frame_mode;
        wr_bank       <= ~wr_bank;
      end
    end
  end

endmodule

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 SHALL have parameter N, default 8: FFT size, a power of two in 8..256; it matches the N of the upstream FFT engine.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have port frame_in, input, complex_product_t [N-1:0]: one bit-corrected FFT frame, index k = bin k.
REQ-005 SHALL have port frame_valid, input, 1 bit: frame_in is valid this cycle; one-cycle pulse from the FFT engine out_valid; no backpressure upstream.
REQ-006 SHALL have port frame_mode, input, 1 bit: the FFT output_mode tag, captured with the frame.
REQ-007 SHALL have port out_data, output, complex_product_t: the current serialized bin.
REQ-008 SHALL have port out_index, output, $clog2(N) bits: the bin number of out_data.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data, out_index, out_last and out_mode are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-011 SHALL have port out_last, output, 1 bit: high with out_index == N-1.
REQ-012 SHALL have port out_mode, output, 1 bit: the frame_mode captured with the frame being streamed.
REQ-013 SHALL have port overflow, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-014 SHALL have port drop_count, output, 8 bits: saturating count of dropped frames.

Function
REQ-015 SHALL hold two frame banks (ping-pong), each with a full flag and a mode bit, plus a write pointer wr_bank, a read pointer rd_bank and a read index rd_idx.
REQ-016 SHALL capture the frame when frame_valid is high and bank[wr_bank] is available: all N entries and frame_mode are stored in one cycle; full[wr_bank] is set and wr_bank toggles at the next edge.
REQ-017 SHALL treat a bank as available if it is not full, or if it is full, equals rd_bank, and its final transfer (out_last handshake) occurs in the same cycle; that bank is refilled without loss.
REQ-018 SHALL drop the frame when frame_valid is high and no bank is available: no state change to the banks, overflow=1 for the next cycle, and drop_count incremented, saturating at 255.
REQ-019 SHALL drive out_valid = full[rd_bank], and out_data = bank[rd_bank][rd_idx], out_index = rd_idx, out_mode = mode[rd_bank].
REQ-020 SHALL have latency of one cycle: a frame_valid at edge t into an empty block gives out_valid=1 with out_index=0 after edge t.
REQ-021 SHALL hold out_data, out_index, out_last and out_mode stable while out_valid && !out_ready; out_valid is never withdrawn without a transfer, except on reset.
REQ-022 SHALL increment rd_idx on each transfer.
REQ-023 SHALL, on a transfer with rd_idx == N-1: wrap rd_idx to 0, clear full[rd_bank] (unless refilled per REQ-017), and toggle rd_bank.
REQ-024 SHALL stream back-to-back with no bubble: if the other bank is full at the last transfer, out_valid stays 1 and the next cycle presents its bin 0.
REQ-025 SHALL emit frames strictly in capture order; each accepted frame is emitted exactly once, in bins 0..N-1.
REQ-026 SHALL pass data bit-exact: no scaling, rounding or reordering.
REQ-027 SHALL be sized as N x 2 banks of complex_product_t registers; no other storage.

Reset
REQ-028 SHALL, while reset==0 at an edge: clear both full flags, both mode bits, wr_bank, rd_bank and rd_idx; set out_valid=0, out_last=0, out_index=0, out_mode=0, overflow=0 and drop_count=0; out_data is don't-care when out_valid=0.
REQ-029 SHALL ignore frame_valid during reset; a frame in flight mid-stream is discarded with no partial output after reset releases.

Verification
REQ-030 SHALL cover: N=8, out_ready=1, one frame with bin k = {k, -k} -> out_valid for 8 consecutive cycles starting one cycle after frame_valid, out_index 0..7, out_last only at index 7, data bit-exact.
REQ-031 SHALL cover: two frames 1 cycle apart, out_ready=1 -> 16 consecutive transfers with no bubble; out_mode follows each frame's frame_mode.
REQ-032 SHALL cover: out_ready=0 with three frames arriving -> first two captured, third dropped; overflow pulses once, drop_count=1; after out_ready=1, exactly 16 transfers.
REQ-033 SHALL cover: both banks full and frame_valid coincident with the final out_last transfer -> frame accepted, overflow=0, and its bin 0 follows the second buffered frame.
REQ-034 SHALL cover: random out_ready toggling -> outputs stable while stalled; the output sequence matches the reference model.
REQ-035 SHALL cover: reset asserted mid-frame at out_index=3 -> the next cycle has out_valid=0 and drop_count=0; a new frame afterwards streams from index 0.
